dcache_ctrl: RTL

//  Blocking controller for the direct-mapped, 256-set, 16-byte-line data cache memory.

---
 rtl/dcache_ctrl_pkg.sv | 47 ++++
 rtl/dcache_refill_buf.sv | 41 ++++
 rtl/dcache_ctrl.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/dcache_ctrl_pkg.sv
// Shared definitions for the blocking data-cache controller: address split,
// FSM state encodings, op codes, the latched CPU request and line helpers.
package dcache_ctrl_pkg;

   localparam int TAG_W      = 20;
   localparam int INDEX_W    = 8;
   localparam int OFFSET_W   = 4;
   localparam int LINE_WORDS = 4;
   localparam int LINE_W     = LINE_WORDS * 32;

   localparam logic OP_LOAD  = 1'b0;
   localparam logic OP_STORE = 1'b1;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_LOOKUP  = 3'd1;
   localparam logic [2:0] S_WB      = 3'd2;
   localparam logic [2:0] S_RD_REQ  = 3'd3;
   localparam logic [2:0] S_RD_WAIT = 3'd4;
   localparam logic [2:0] S_REFILL  = 3'd5;

   typedef struct packed {
      logic        op;
      logic [31:0] addr;
      logic [3:0]  wstrb;
      logic [31:0] wdata;
   } cpu_req_t;

   // Overlay the enabled bytes of new_w onto old_w.
   function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  strb);
      logic [31:0] w;
      w = old_w;
      for (int b = 0; b < 4; b++)
         if (strb[b]) w[b*8 +: 8] = new_w[b*8 +: 8];
      return w;
   endfunction

   // Pick one 32-bit word out of a line; word 0 sits in the low bits.
   function automatic logic [31:0] line_word(input logic [LINE_W-1:0] line,
                                             input logic [1:0]        sel);
      logic [LINE_WORDS-1:0][31:0] w;
      w = line;
      return w[sel];
   endfunction

endpackage

// File: rtl/dcache_refill_buf.sv
// Refill line assembly: stores incoming bus beats at the beat counter and
// presents the assembled line with any pending store bytes merged in.
module dcache_refill_buf
   import dcache_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              beat_en,
   input  logic [31:0]       beat_data,
   input  logic              merge_en,
   input  logic [1:0]        merge_sel,
   input  logic [3:0]        merge_strb,
   input  logic [31:0]       merge_data,
   output logic [LINE_W-1:0] line
);

   logic [LINE_WORDS-1:0][31:0] buf_q;
   logic [LINE_WORDS-1:0][31:0] merged;
   logic [1:0]                  cnt;

   // Each accepted beat lands in the word the counter points at; the 2-bit
   // counter wraps after the fourth beat so the next miss starts at word 0.
   always_ff @(posedge clk) begin
      if (reset) begin
         buf_q <= '0;
         cnt   <= '0;
      end else if (beat_en) begin
         buf_q[cnt] <= beat_data;
         cnt        <= cnt + 2'd1;
      end
   end

   // A store miss writes its bytes into the refilled line on the way to the RAM.
   always_comb begin
      merged = buf_q;
      if (merge_en)
         merged[merge_sel] = merge_bytes(buf_q[merge_sel], merge_data, merge_strb);
      line = merged;
   end

endmodule

// File: rtl/dcache_ctrl.sv
// Blocking controller for a direct-mapped 256-set, 16-byte-line data cache.
// Tag compare runs on the cache memory's registered outputs; misses write back
// a dirty victim as one 128-bit burst, then refill from four 32-bit beats.
module dcache_ctrl
   import dcache_ctrl_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic                req_valid,
   input  logic                req_op,
   input  logic [31:0]         req_addr,
   input  logic [3:0]          req_wstrb,
   input  logic [31:0]         req_wdata,
   output logic                req_addr_ok,
   output logic                resp_valid,
   output logic [31:0]         resp_rdata,
   output logic [TAG_W-1:0]    cm_wtag,
   output logic [INDEX_W-1:0]  cm_index,
   output logic [OFFSET_W-1:0] cm_offset,
   output logic                cm_hit,
   output logic                cm_refill,
   output logic                cm_set_D,
   output logic [3:0]          cm_wstrb,
   output logic [31:0]         cm_wdata,
   output logic [LINE_W-1:0]   cm_refill_data,
   input  logic                cm_v,
   input  logic                cm_D,
   input  logic [TAG_W-1:0]    cm_rtag,
   input  logic [LINE_W-1:0]   cm_rdata,
   output logic                rd_req,
   output logic [31:0]         rd_addr,
   input  logic                rd_rdy,
   input  logic                ret_valid,
   input  logic                ret_last,
   input  logic [31:0]         ret_data,
   output logic                wr_req,
   output logic [31:0]         wr_addr,
   output logic [LINE_W-1:0]   wr_data,
   input  logic                wr_rdy
);

   logic [2:0]         state;
   logic [2:0]         state_nxt;
   cpu_req_t           req_r;
   logic [31:0]        victim_addr;
   logic [LINE_W-1:0]  victim_line;
   logic [LINE_W-1:0]  refill_line;

   logic [TAG_W-1:0]   tag_r;
   logic [INDEX_W-1:0] index_r;
   logic [1:0]         word_r;
   logic               is_store;
   logic               hit;
   logic               accept;

   assign tag_r    = req_r.addr[31:12];
   assign index_r  = req_r.addr[11:4];
   assign word_r   = req_r.addr[3:2];
   assign is_store = (req_r.op == OP_STORE);
   assign hit      = cm_v & (cm_rtag == tag_r);
   assign accept   = req_valid & (state == S_IDLE);

   dcache_refill_buf u_refill_buf (
      .clk        (clk),
      .reset      (reset),
      .beat_en    (ret_valid & (state == S_RD_WAIT)),
      .beat_data  (ret_data),
      .merge_en   (is_store),
      .merge_sel  (word_r),
      .merge_strb (req_r.wstrb),
      .merge_data (req_r.wdata),
      .line       (refill_line)
   );

   // State register; reset drops any in-flight miss on the floor.
   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // Next-state: one request at a time, miss path WB -> RD_REQ -> RD_WAIT -> REFILL.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:    if (req_valid) state_nxt = S_LOOKUP;
         S_LOOKUP:  if (hit)                state_nxt = S_IDLE;
                    else if (cm_v & cm_D)   state_nxt = S_WB;
                    else                    state_nxt = S_RD_REQ;
         S_WB:      if (wr_rdy)   state_nxt = S_RD_REQ;
         S_RD_REQ:  if (rd_rdy)   state_nxt = S_RD_WAIT;
         S_RD_WAIT: if (ret_last) state_nxt = S_REFILL;
         S_REFILL:  state_nxt = S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
   end

   // Capture the CPU request when it is accepted; held for the whole transaction.
   always_ff @(posedge clk) begin
      if (reset)
         req_r <= '0;
      else if (accept)
         req_r <= '{op: req_op, addr: req_addr, wstrb: req_wstrb, wdata: req_wdata};
   end

   // Snapshot the resident line on a miss so the writeback burst is stable
   // even after the RAM read port moves on.
   always_ff @(posedge clk) begin
      if (reset) begin
         victim_addr <= '0;
         victim_line <= '0;
      end else if ((state == S_LOOKUP) && !hit) begin
         victim_addr <= {cm_rtag, index_r, 4'b0};
         victim_line <= cm_rdata;
      end
   end

   // Cache-memory controls and CPU response, decoded from the current state.
   always_comb begin
      req_addr_ok = accept;
      cm_index    = (state == S_IDLE) ? req_addr[11:4] : index_r;
      cm_offset   = (state == S_IDLE) ? req_addr[3:0]  : req_r.addr[3:0];
      cm_wtag     = tag_r;
      cm_hit      = 1'b0;
      cm_refill   = 1'b0;
      cm_set_D    = 1'b0;
      cm_wstrb    = '0;
      cm_wdata    = '0;
      resp_valid  = 1'b0;
      resp_rdata  = '0;
      case (state)
         S_LOOKUP: begin
            if (hit) begin
               resp_valid = 1'b1;
               if (is_store) begin
                  cm_hit   = 1'b1;
                  cm_set_D = 1'b1;
                  cm_wstrb = req_r.wstrb;
                  cm_wdata = req_r.wdata;
               end else begin
                  resp_rdata = line_word(cm_rdata, word_r);
               end
            end
         end
         S_REFILL: begin
            cm_refill  = 1'b1;
            cm_set_D   = is_store;
            resp_valid = 1'b1;
            resp_rdata = line_word(refill_line, word_r);
         end
         default: ;
      endcase
   end

   assign cm_refill_data = refill_line;
   assign wr_req         = (state == S_WB);
   assign wr_addr        = victim_addr;
   assign wr_data        = victim_line;
   assign rd_req         = (state == S_RD_REQ);
   assign rd_addr        = {tag_r, index_r, 4'b0};

endmodule
